// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the RV core: sequences FETCH/DECODE/EXEC/MEM/WB
// over ready-handshaked memories, with memory-wait timeout and a sticky trap.
module multicycle_control_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ENABLE_JAL     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       dmem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       branch,
  output logic       jump,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_next;
  logic [6:0] opcode_q;
  logic [7:0] wait_cnt;
  logic [1:0] cause_next;
  logic       opcode_legal;

  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: opcode_legal = 1'b1;
      OP_JAL:                                   opcode_legal = (ENABLE_JAL != 0);
      default:                                  opcode_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      opcode_q   <= 7'd0;
      wait_cnt   <= 8'd0;
      trap_cause <= 2'b00;
    end else begin
      state      <= state_next;
      trap_cause <= cause_next;
      if (state == S_DECODE) opcode_q <= opcode;
      // Any state change restarts the wait window for the state being entered.
      if (state_next != state)
        wait_cnt <= 8'd0;
      else if ((state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready))
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = trap_cause;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    dmem_req   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    trap       = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end
      end
      S_DECODE: begin
        if (opcode_legal) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_TRAP;
          cause_next = 2'b01;
        end
      end
      S_EXEC: begin
        case (opcode_q)
          OP_R: begin
            alu_op     = 2'b10;
            state_next = S_WB;
          end
          OP_I: begin
            alu_op     = 2'b10;
            alu_src    = 1'b1;
            state_next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src    = 1'b1;
            state_next = S_MEM;
          end
          OP_BRANCH: begin
            alu_op     = 2'b01;
            branch     = 1'b1;
            state_next = S_FETCH;
          end
          OP_JAL: begin
            jump       = 1'b1;
            state_next = S_WB;
          end
          default: begin
            state_next = S_TRAP;
            cause_next = 2'b01;
          end
        endcase
      end
      S_MEM: begin
        // Strobes are pure functions of state and opcode_q, so they stay stable while waiting.
        dmem_req  = 1'b1;
        mem_read  = (opcode_q == OP_LOAD);
        mem_write = (opcode_q == OP_STORE);
        if (dmem_ready) begin
          state_next = (opcode_q == OP_LOAD) ? S_WB : S_FETCH;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = S_TRAP;
          cause_next = 2'b11;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode_q == OP_LOAD) ? 2'b01 :
                     (opcode_q == OP_JAL)  ? 2'b10 : 2'b00;
        state_next = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  assign state_o = state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder for the RV core.
- An FSM sequences FETCH/DECODE/EXEC/MEM/WB over shared instruction and data memories using ready handshakes.
- Adds memory-wait timeout detection, an optional JAL class, a widened writeback select, and a sticky trap state.
- Sits between the instruction register (opcode source) and the datapath muxes, register file and memory ports.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive not-ready cycles tolerated in FETCH or MEM before trapping; legal range 2..255.
- ENABLE_JAL, 1: 1 = opcode 1101111 is legal (jump class); 0 = that opcode is illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instr[6:0] from the instruction register; sampled only in DECODE.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  PC <= PC+4.
- dmem_req  out  1  data memory request.
- mem_read  out  1  data read strobe.
- mem_write  out  1  data write strobe.
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded.
- alu_src  out  1  1 = immediate operand.
- branch  out  1  conditional PC load if ALU zero.
- jump  out  1  unconditional PC load with jump target.
- mem_to_reg  out  2  writeback select: 00 ALU, 01 memory, 10 link (PC+4).
- reg_write  out  1  register file write enable.
- trap  out  1  high while in TRAP.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- state_o  out  3  current state, for debug.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- Reset (rst_n low, asynchronous): state IDLE, opcode_q=0, wait counter 0, trap_cause 00. All outputs decode to 0 in IDLE.
- IDLE -> FETCH unconditionally on the first clock edge after reset release.
- All outputs except trap_cause are combinational from state, opcode_q and the ready inputs. Unlisted outputs are 0 in every state.
- FETCH:
  - imem_req=1.
  - If imem_ready: ir_write=1 and pc_write=1 in the same cycle, then -> DECODE.
  - Else the wait counter increments.
- DECODE:
  - opcode_q <= opcode.
  - Legal classes: 0110011, 0010011, 0000011, 0100011, 1100011, and 1101111 when ENABLE_JAL=1.
  - Legal -> EXEC. Illegal -> TRAP with cause 01.
- EXEC (one cycle):
  - R-type: alu_op=10, alu_src=0, -> WB.
  - I-type: alu_op=10, alu_src=1, -> WB.
  - Load/store: alu_op=00, alu_src=1, -> MEM.
  - Branch: alu_op=01, alu_src=0, branch=1, -> FETCH.
  - JAL: jump=1, -> WB.
- MEM:
  - dmem_req=1; mem_read=1 for load, mem_write=1 for store. Strobes are held stable until dmem_ready.
  - On dmem_ready: load -> WB, store -> FETCH.
- WB (one cycle):
  - reg_write=1, -> FETCH.
  - mem_to_reg is 01 for load, 10 for JAL, 00 otherwise.
- Wait counter:
  - 8 bits; cleared on every transition into FETCH or MEM.
  - Counts each cycle spent in FETCH/MEM with the corresponding ready low.
  - If ready is low and counter == TIMEOUT_CYCLES-1: -> TRAP next edge, cause 10 (FETCH) or 11 (MEM). No memory strobe is asserted in TRAP.
  - Ready high on that same final cycle wins: normal transition, no trap.
- TRAP: trap=1; trap_cause holds its value. Absorbing; exits only via rst_n.
- Reset asserted mid-access (FETCH/MEM): all strobes drop asynchronously. A dmem_ready arriving later is ignored.
- Latency with zero-wait memory: branch 3 cycles; R/I/JAL/store 4 cycles; load 5 cycles.
- Each additional wait cycle adds 1 cycle.

Test Plan:
- Reset release, imem_ready=1, opcode=0110011:
  - state_o sequence 0,1,2,3,5,1.
  - reg_write=1 only in WB with mem_to_reg=00; alu_op=10 and alu_src=0 in EXEC.
- Load 0000011, dmem_ready low 3 cycles then high:
  - MEM lasts 4 cycles with dmem_req=1 and mem_read=1 throughout.
  - Then WB with mem_to_reg=01; total 8 cycles FETCH-to-FETCH.
- Store 0100011 and beq 1100011 back-to-back, zero wait:
  - Store: mem_write=1 in MEM, no reg_write, 4 cycles.
  - beq: branch=1 and alu_op=01 in EXEC, returns to FETCH after 3 cycles.
- opcode=1101111:
  - ENABLE_JAL=1: jump=1 in EXEC, then WB with mem_to_reg=10.
  - ENABLE_JAL=0: TRAP, trap_cause=01; stays there until rst_n pulse, then IDLE.
- TIMEOUT_CYCLES=4, imem_ready held low:
  - TRAP after 4 FETCH cycles, cause 10.
  - Repeat with imem_ready rising on the 4th cycle: no trap, -> DECODE.
- Assert rst_n low mid-MEM with mem_write=1:
  - All outputs 0 immediately (before the next edge); state_o=0.
